// File: rtl/mp_pkg.sv
// Shared types for the core bus responder: core ids, the response stage record and the id step helper.
// No logic or state here; latency and backpressure belong to the modules that import it.
package mp_pkg;

    localparam int NC = 3;
    localparam int DW = 8;

    typedef logic [1:0] core_id_t;

    typedef struct packed {
        logic          valid;
        core_id_t      id;
        logic [DW-1:0] data;
    } resp_t;

    // Successor in the 0,1,2 rotation; ids never reach 3.
    function automatic core_id_t next_id(core_id_t id);
        return (id == core_id_t'(NC - 1)) ? '0 : id + core_id_t'(1);
    endfunction

endpackage

// File: rtl/shared_mem_resp_if.sv
// Core bus between three generator cores and the shared memory responder.
// Grants are combinational; responses arrive one cycle after acceptance; cores hold requests until granted.
interface shared_mem_resp_if #(
    parameter int AW = 11,
    parameter int DW = 8,
    parameter int NC = 3
);
    logic [NC-1:0]         req;
    logic [NC-1:0]         we;
    logic [NC-1:0][AW-1:0] addr;
    logic [NC-1:0][DW-1:0] wdata;
    logic [NC-1:0]         gnt;
    logic [NC-1:0]         rvalid;
    logic [NC-1:0][DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational grant starting the search at ptr, ptr moves past each accepted core.
// Zero latency grant; a requester not granted simply keeps req high and waits at most two cycles.
module rr_arbiter3
    import mp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       accept,
    output logic [2:0] gnt,
    output core_id_t   gnt_id
);

    core_id_t ptr_q;
    core_id_t ptr_d;
    core_id_t cand;
    logic     found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt    = '0;
        gnt_id = ptr_q;
        found  = 1'b0;
        cand   = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_id    = cand;
                found     = 1'b1;
            end
            cand = next_id(cand);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = next_id(gnt_id);
        end
    end

endmodule

// File: rtl/shared_mem_resp.sv
// Shared single-port memory responder: arbitrates three cores, one access per cycle, per-core response.
// Response one cycle after acceptance; ungranted cores hold their request (no other backpressure).
module shared_mem_resp
    import mp_pkg::resp_t, mp_pkg::core_id_t;
#(
    parameter int AW = 11,
    parameter int DW = mp_pkg::DW,
    parameter int NC = mp_pkg::NC
) (
    input  logic            clk,
    input  logic            rst_n,
    shared_mem_resp_if.slave bus
);

    logic [NC-1:0] gnt;
    core_id_t      gnt_id;
    logic          accept;
    logic          we_sel;
    logic          wr_en;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;
    logic [DW-1:0] mem [2**AW];

    resp_t resp_d;
    resp_t resp_q;

    logic [NC-1:0]         rvalid_c;
    logic [NC-1:0][DW-1:0] rdata_c;

    rr_arbiter3 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req),
        .accept (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign accept    = |(bus.req & gnt);
    assign we_sel    = bus.we[gnt_id];
    assign addr_sel  = bus.addr[gnt_id];
    assign wdata_sel = bus.wdata[gnt_id];
    // Writes are suppressed while reset is held so memory survives a reset.
    assign wr_en     = rst_n & accept & we_sel;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_sel] <= wdata_sel;
        end
    end

    // Reads capture the pre-edge contents; writes echo their own data.
    always_comb begin
        resp_d       = '0;
        resp_d.valid = accept;
        resp_d.id    = gnt_id;
        if (accept) begin
            resp_d.data = we_sel ? wdata_sel : mem[addr_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else begin
            resp_q <= resp_d;
        end
    end

    always_comb begin
        rvalid_c = '0;
        rdata_c  = '0;
        if (resp_q.valid) begin
            rvalid_c[resp_q.id] = 1'b1;
            rdata_c[resp_q.id]  = resp_q.data;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_c;
    assign bus.rdata  = rdata_c;

endmodule

// File: tb/tb_shared_mem_resp.sv
// Bench for shared_mem_resp: a cycle model of the responder checked every cycle, plus directed literal checks.
module tb_shared_mem_resp;

    logic clk;
    logic rst_n;

    shared_mem_resp_if bus ();

    shared_mem_resp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pointer, expected response and memory image.
    int         mptr = 0;
    int         mg_now;
    logic       ev_valid = 1'b0;
    int         ev_id = 0;
    logic [7:0] ev_data = 8'h00;
    bit         ev_known = 1'b0;
    logic [7:0] mmem [2048];
    bit         mknown [2048];

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    always_comb mg_now = pick(bus.req, mptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mptr     <= 0;
            ev_valid <= 1'b0;
        end else if (mg_now >= 0) begin
            ev_valid <= 1'b1;
            ev_id    <= mg_now;
            mptr     <= (mg_now + 1) % 3;
            if (bus.we[mg_now]) begin
                ev_data                       <= bus.wdata[mg_now];
                ev_known                      <= 1'b1;
                mmem[int'(bus.addr[mg_now])]   <= bus.wdata[mg_now];
                mknown[int'(bus.addr[mg_now])] <= 1'b1;
            end else begin
                ev_data  <= mmem[int'(bus.addr[mg_now])];
                ev_known <= mknown[int'(bus.addr[mg_now])];
            end
        end else begin
            ev_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("gnt", 32'(bus.gnt), (mg_now >= 0) ? (32'd1 << mg_now) : 32'd0);
        chk("rvalid", 32'(bus.rvalid), ev_valid ? (32'd1 << ev_id) : 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (ev_valid && ev_id == i) begin
                if (ev_known) chk("rdata_lane", 32'(bus.rdata[i]), 32'(ev_data));
            end else begin
                chk("rdata_idle", 32'(bus.rdata[i]), 32'd0);
            end
        end
    end

    task automatic drive(input logic [2:0] r, input logic [2:0] w,
                         input logic [10:0] a0, input logic [10:0] a1, input logic [10:0] a2,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        bus.req      = r;
        bus.we       = w;
        bus.addr[0]  = a0;
        bus.addr[1]  = a1;
        bus.addr[2]  = a2;
        bus.wdata[0] = d0;
        bus.wdata[1] = d1;
        bus.wdata[2] = d2;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    logic [2:0] exp_g [6];
    logic [2:0] prev_g;

    initial begin
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
        rst_n = 1'b0;
        drive(3'b111, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        step; step;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h1);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        rst_n = 1'b1;
        step;
        #1 chk("post_rst_rvalid", 32'(bus.rvalid), 32'h0);

        // Core 1 write then read of 0x123.
        drive(3'b010, 3'b010, 11'h0, 11'h123, 11'h0, 8'h0, 8'hA5, 8'h0);
        #1 chk("c1_wr_gnt", 32'(bus.gnt), 32'h2);
        step;
        drive(3'b010, 3'b000, 11'h0, 11'h123, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("c1_wr_rvalid", 32'(bus.rvalid), 32'h2);
        chk("c1_wr_echo", 32'(bus.rdata[1]), 32'hA5);
        step;
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("c1_rd_data", 32'(bus.rdata[1]), 32'hA5);
        chk("c1_rd_lane0", 32'(bus.rdata[0]), 32'h0);
        chk("c1_rd_lane2", 32'(bus.rdata[2]), 32'h0);

        // Core 2 writes 0x11 to 0x000, leaving ptr at 0.
        drive(3'b100, 3'b100, 11'h0, 11'h0, 11'h000, 8'h0, 8'h0, 8'h11);
        step;

        // Full contention for six cycles.
        prev_g = 3'b100;
        drive(3'b111, 3'b000, 11'h000, 11'h123, 11'h123, 8'h0, 8'h0, 8'h0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_gnt", 32'(bus.gnt), 32'(exp_g[c]));
            chk("rr_rvalid", 32'(bus.rvalid), 32'(prev_g));
            prev_g = exp_g[c];
            step;
        end
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("rr_last_rvalid", 32'(bus.rvalid), 32'h4);
        chk("rr_last_data", 32'(bus.rdata[2]), 32'hA5);

        // Core 0 read moves ptr to 1, then only cores 0 and 2 request.
        drive(3'b001, 3'b000, 11'h000, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        step;
        drive(3'b101, 3'b000, 11'h000, 11'h0, 11'h000, 8'h0, 8'h0, 8'h0);
        #1 chk("skip_gnt0", 32'(bus.gnt), 32'h4);
        step;
        #1 chk("skip_gnt1", 32'(bus.gnt), 32'h1);
        step;
        drive(3'b111, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("skip_ptr1", 32'(bus.gnt), 32'h2);
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        step;

        // Cross-core sharing through 0x7FF and 0x000.
        drive(3'b001, 3'b001, 11'h7FF, 11'h0, 11'h0, 8'h3C, 8'h0, 8'h0);
        step;
        drive(3'b100, 3'b000, 11'h0, 11'h0, 11'h7FF, 8'h0, 8'h0, 8'h0);
        #1 chk("x_wr_echo", 32'(bus.rdata[0]), 32'h3C);
        step;
        drive(3'b100, 3'b100, 11'h0, 11'h0, 11'h000, 8'h0, 8'h0, 8'h11);
        #1 chk("x_rd_rvalid", 32'(bus.rvalid), 32'h4);
        chk("x_rd_data", 32'(bus.rdata[2]), 32'h3C);
        step;
        drive(3'b010, 3'b000, 11'h0, 11'h000, 11'h0, 8'h0, 8'h0, 8'h0);
        step;
        drive(3'b010, 3'b000, 11'h0, 11'h7FF, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("x_mem0", 32'(bus.rdata[1]), 32'h11);
        step;
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("x_7ff_kept", 32'(bus.rdata[1]), 32'h3C);

        // Reset while core 1's response is in flight; writes during reset must not land.
        drive(3'b010, 3'b000, 11'h0, 11'h7FF, 11'h0, 8'h0, 8'h0, 8'h0);
        step;
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("mid_rvalid_pre", 32'(bus.rvalid), 32'h2);
        rst_n = 1'b0;
        #1 chk("mid_rvalid_drop", 32'(bus.rvalid), 32'h0);
        drive(3'b111, 3'b111, 11'h7FF, 11'h7FF, 11'h7FF, 8'hEE, 8'hEE, 8'hEE);
        #1 chk("mid_rst_gnt", 32'(bus.gnt), 32'h1);
        step; step;
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        rst_n = 1'b1;
        step;
        drive(3'b111, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("mid_ptr0", 32'(bus.gnt), 32'h1);
        drive(3'b010, 3'b000, 11'h0, 11'h7FF, 11'h0, 8'h0, 8'h0, 8'h0);
        step;
        drive(3'b000, 3'b000, 11'h0, 11'h0, 11'h0, 8'h0, 8'h0, 8'h0);
        #1 chk("mid_retained_v", 32'(bus.rvalid), 32'h2);
        chk("mid_retained_d", 32'(bus.rdata[1]), 32'h3C);
        step; step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_mem_resp.md
# shared_mem_resp

Responder side of the core bus: it replaces the stub grant/response logic in the multiprocessor top level. Three generator cores issue `req`/`we`/`addr`/`wdata`. This block arbitrates round-robin, performs one access per cycle on a single-port 2^AW × DW memory, and returns a per-core `rvalid`/`rdata` response one cycle after each accepted access.

## Interface
- `AW`, 11: address width; memory depth is 2^AW words.
- `DW`, 8: data width.
- `NC`, 3: number of cores. Fixed at 3; other values are unsupported.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  [NC-1:0]  per-core request. Held with `we`/`addr`/`wdata` stable until granted.
- `we`  in  [NC-1:0]  per-core write enable (1 = write, 0 = read).
- `addr`  in  [NC-1:0][AW-1:0]  per-core word address.
- `wdata`  in  [NC-1:0][DW-1:0]  per-core write data.
- `gnt`  out  [NC-1:0]  one-hot or zero. Combinational from `req` and the arbiter pointer.
- `rvalid`  out  [NC-1:0]  registered one-cycle response pulse, at most one bit set.
- `rdata`  out  [NC-1:0][DW-1:0]  registered per-core response data. Zero when that core's `rvalid` is 0.

## Operation
- **Arbitration**
  - Pointer `ptr` ∈ {0,1,2}; reset value 0.
  - Search order is `ptr`, `ptr+1`, `ptr+2` (mod 3). The first core with `req` set receives `gnt`.
  - `gnt` is never asserted to a core whose `req` is low. `gnt` = 0 when no request is pending.
- **Transfer**
  - An access is accepted at a rising edge where `req[i] & gnt[i]` holds.
  - On acceptance `ptr` becomes `(i+1) mod 3`. With no acceptance, `ptr` holds.
- **Write**
  - `mem[addr[i]] <= wdata[i]` at the accepting edge.
  - Response `rdata[i]` = `wdata[i]`, an echo acknowledge.
- **Read**
  - Response `rdata[i]` = `mem[addr[i]]` as sampled at the accepting edge, i.e. the old contents.
- **Response register**
  - One stage holding `{valid, core_id, data}`.
  - Drives `rvalid[core_id]` and `rdata[core_id]`; all other lanes read zero.
- **Memory contents**
  - The memory is not reset; contents are undefined until written.
  - Reset does not clear memory, so data written before a reset is retained across it.
- **Back-to-back access**
  - Accesses may be accepted on every cycle.
  - A read of an address written in the immediately preceding cycle returns the new data, because the write completed at the earlier edge.

## Timing
- **Reset values:** `rvalid` = 0, `rdata` = 0, `ptr` = 0. `gnt` follows `req` combinationally with `ptr` = 0 during and after reset.
- **During reset:** no memory write occurs while `rst_n` is low, even if `req & gnt` is high.
- **Latency:** acceptance at edge N gives `rvalid[i]` = 1 during cycle N→N+1, for exactly one cycle.
- **Throughput:** 1 access/cycle total; at most 1 grant per cycle.
- **Fairness:** with all three requesting continuously, grants rotate 0,1,2,0,...; each core waits ≤ 2 cycles.
- **Reset mid-operation:** an in-flight response is dropped (`rvalid` cleared asynchronously); `ptr` returns to 0.
- **Simultaneous request and response:** a core may receive `rvalid` for its previous access and `gnt` for its next access in the same cycle.
- **Address wrap-around:** `addr` is used modulo 2^AW; there is no out-of-range condition.

## Structure
- **Package `mp_pkg`**
  - `NC` = 3.
  - `typedef logic [1:0] core_id_t`.
  - `typedef struct packed {logic valid; core_id_t id; logic [DW-1:0] data;} resp_t`, parameterised via localparam DW = 8.
- **Sub-module `rr_arbiter3`**
  - Inputs: `clk`, `rst_n`, `req[2:0]`, `accept`.
  - Outputs: `gnt[2:0]`, `gnt_id`.
  - Owns `ptr` and its update rule.
- **Top of this block:** memory array, response register, and output lane demux.

## Test plan
- **Reset:** hold `rst_n` = 0 with all `req` = 1 → `rvalid` = 0, `rdata` = 0, `gnt` = 3'b001. After release, no stale response appears.
- **Single core write then read:**
  - Core 1 writes 0xA5 to 0x123 → `gnt` = 3'b010, next cycle `rvalid` = 3'b010 with `rdata[1]` = 0xA5.
  - Core 1 then reads 0x123 → `rdata[1]` = 0xA5. `rdata[0]` and `rdata[2]` stay 0.
- **Full contention:** all cores request for 6 cycles → `gnt` sequence 001,010,100,001,010,100, with `rvalid` the same sequence delayed 1 cycle.
- **Pointer skip:** `ptr` = 1, only cores 0 and 2 request → `gnt` 100 then 001, then `ptr` = 1.
- **Cross-core sharing:**
  - Core 0 writes 0x3C to 0x7FF; the next cycle core 2 reads 0x7FF → `rdata[2]` = 0x3C.
  - Core 2 writes 0x11 to address 0x000 → `mem[0]` = 0x11; address 0x7FF is unchanged.
- **Reset mid-response:** assert `rst_n` = 0 in the cycle `rvalid[1]` = 1 → `rvalid` drops immediately and `ptr` = 0. After release, a read of the previously written address still returns the written data.
